// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
//   Shared definitions for the Zicsr access sequencer:
//     - funct3 encodings of the six Zicsr instructions
//     - csr_write_type encodings seen by the CSR file
//     - addresses of the machine-mode CSRs the core implements
//     - sequencer state enum
//     - small helper to classify read-only CSR addresses
// ---------------------------------------------------------------------------
package csr_pkg;

    localparam int XLEN_DEFAULT   = 32;
    localparam int CSR_AW_DEFAULT = 12;

    // Zicsr funct3 encodings. Bit 2 selects the immediate form, bits [1:0]
    // select write/set/clear. 000 and 100 are not CSR operations.
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // Write type presented to the CSR file. The encoding is funct3[1:0]
    // so decode is a plain copy; NONE is what the bus shows when idle.
    typedef enum logic [1:0] {
        WT_NONE  = 2'b00,
        WT_WRITE = 2'b01,
        WT_SET   = 2'b10,
        WT_CLR   = 2'b11
    } write_type_t;

    // Machine-mode CSR addresses.
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WRITE  = 3'd2,
        RETIRE = 3'd3,
        FAULT  = 3'd4
    } state_t;

    // CSR address bits [11:10] == 11 mark the read-only region.
    function automatic logic csr_is_read_only(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_op_decode.sv
// ---------------------------------------------------------------------------
// csr_op_decode
//   Purely combinational classification of a Zicsr instruction. The
//   sequencer uses these flags at launch to pick its first state and keeps
//   copies of the ones it needs later in the operation.
//
// Ports
//   instr       in   [31:7]  instruction without the opcode field
//   write_type  out  2       write/set/clear encoding from funct3[1:0]
//   use_imm     out  1       immediate form: write data is zero-extended zimm
//   skip_read   out  1       CSRRW/CSRRWI with rd==x0: no read side effect
//   skip_write  out  1       set/clear with rs1/zimm==0: no write side effect
//   bad_op      out  1       funct3 is 000 or 100 (not a CSR op)
//   ro_hit      out  1       read-only CSR targeted by an op that will write
// ---------------------------------------------------------------------------
module csr_op_decode
    import csr_pkg::*;
(
    input  logic [31:7]  instr,
    output write_type_t  write_type,
    output logic         use_imm,
    output logic         skip_read,
    output logic         skip_write,
    output logic         bad_op,
    output logic         ro_hit
);

    logic [11:0] csr;
    logic [4:0]  rs1_zimm;
    logic [2:0]  funct3;
    logic [4:0]  rd;

    assign csr      = instr[31:20];
    assign rs1_zimm = instr[19:15];
    assign funct3   = instr[14:12];
    assign rd       = instr[11:7];

    assign write_type = write_type_t'(funct3[1:0]);
    assign use_imm    = funct3[2];
    assign bad_op     = funct3[1:0] == 2'b00;

    // Plain write with rd==x0 must not read (reads may have side effects);
    // set/clear with a zero operand must not write.
    assign skip_read  = (funct3[1:0] == 2'b01) && (rd == 5'd0);
    assign skip_write = (funct3[1:0] != 2'b01) && (rs1_zimm == 5'd0);

    // Reading a read-only CSR is fine; only an actual write attempt faults.
    assign ro_hit     = csr_is_read_only(csr) && !skip_write;

endmodule

// File: rtl/csr_sequencer.sv
// ---------------------------------------------------------------------------
// csr_sequencer
//   Initiator side of the CSR access bus. Executes one Zicsr instruction at a
//   time: optional read of the old value, optional write of the new value
//   over the shared tristate bus, then either retires with an rd write-back
//   or reports an illegal instruction.
// ---------------------------------------------------------------------------
module csr_sequencer
    import csr_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int CSR_AW = CSR_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       instr,
    input  logic [XLEN-1:0]   rs1_val,
    output logic [CSR_AW-1:0] csr_addr,
    inout  wire  [XLEN-1:0]   csr_bus,
    output logic              csr_read,
    output logic              csr_write,
    output logic [1:0]        csr_write_type,
    input  logic              csr_invalid,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic              rd_we,
    output logic [4:0]        rd_addr,
    output logic [XLEN-1:0]   rd_data
);

    // -----------------------------------------------------------------------
    // Decode of the incoming instruction (only meaningful at launch)
    // -----------------------------------------------------------------------
    write_type_t dec_write_type;
    logic        dec_use_imm;
    logic        dec_skip_read;
    logic        dec_skip_write;
    logic        dec_bad_op;
    logic        dec_ro_hit;

    csr_op_decode u_decode (
        .instr      (instr[31:7]),
        .write_type (dec_write_type),
        .use_imm    (dec_use_imm),
        .skip_read  (dec_skip_read),
        .skip_write (dec_skip_write),
        .bad_op     (dec_bad_op),
        .ro_hit     (dec_ro_hit)
    );

    // The opcode field is checked upstream; this block only sees CSR ops.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    // -----------------------------------------------------------------------
    // State and latched operands
    // -----------------------------------------------------------------------
    state_t          state;
    state_t          state_nxt;
    logic [31:7]     instr_q;       // csr, rs1/zimm, funct3, rd of the op in flight
    logic [XLEN-1:0] wdata_q;       // already resolved to rs1_val or zimm
    write_type_t     wt_q;
    logic            skip_write_q;
    logic            did_read_q;    // a READ completed for the op in flight
    logic [XLEN-1:0] old_val;
    logic            bus_drive;

    logic            launch;
    logic [XLEN-1:0] launch_wdata;

    assign launch       = start && (state == IDLE);
    assign launch_wdata = dec_use_imm ? {{(XLEN-5){1'b0}}, instr[19:15]} : rs1_val;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // state_nxt unassigned, which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (dec_bad_op || dec_ro_hit) begin
                        state_nxt = FAULT;
                    end else if (dec_skip_read) begin
                        state_nxt = WRITE;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                if (csr_invalid) begin
                    state_nxt = FAULT;
                end else if (skip_write_q) begin
                    state_nxt = RETIRE;
                end else begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = csr_invalid ? FAULT : RETIRE;
            end
            RETIRE:  state_nxt = IDLE;
            FAULT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State, operand latches and registered outputs. Every output is a flop
    // loaded from the state being entered, so strobes and the bus enable
    // change cleanly on the clock edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            instr_q        <= '0;
            wdata_q        <= '0;
            wt_q           <= WT_NONE;
            skip_write_q   <= 1'b0;
            did_read_q     <= 1'b0;
            old_val        <= '0;
            bus_drive      <= 1'b0;
            busy           <= 1'b0;
            csr_read       <= 1'b0;
            csr_write      <= 1'b0;
            csr_write_type <= WT_NONE;
            done           <= 1'b0;
            illegal        <= 1'b0;
            rd_we          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here sees the pre-edge value of every other one regardless of
            // statement order.
            state <= state_nxt;

            if (launch) begin
                instr_q      <= instr[31:7];
                wdata_q      <= launch_wdata;
                wt_q         <= dec_write_type;
                skip_write_q <= dec_skip_write;
                did_read_q   <= 1'b0;
            end

            if (state == READ) begin
                old_val    <= csr_bus;
                did_read_q <= 1'b1;
            end

            busy      <= state_nxt != IDLE;
            csr_read  <= state_nxt == READ;
            csr_write <= state_nxt == WRITE;
            bus_drive <= state_nxt == WRITE;

            // Entering WRITE straight from IDLE means wt_q is being loaded on
            // this same edge, so take the type from the decoder instead.
            if (state_nxt == WRITE) begin
                csr_write_type <= (state == IDLE) ? dec_write_type : wt_q;
            end else begin
                csr_write_type <= WT_NONE;
            end

            done    <= (state_nxt == RETIRE) || (state_nxt == FAULT);
            illegal <= state_nxt == FAULT;

            // RETIRE is entered from READ (read finishing now) or from WRITE
            // (read finished earlier, if at all). A fault never reaches here.
            rd_we <= (state_nxt == RETIRE)
                  && ((state == READ) || did_read_q)
                  && (instr_q[11:7] != 5'd0);
        end
    end

    // -----------------------------------------------------------------------
    // Output assignments
    // -----------------------------------------------------------------------
    assign csr_addr = CSR_AW'(instr_q[31:20]);
    assign rd_addr  = instr_q[11:7];
    assign rd_data  = old_val;
    assign csr_bus  = bus_drive ? wdata_q : {XLEN{1'bz}};

endmodule

// File: tb/tb_csr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_csr_sequencer
//   Directed bench for csr_sequencer. A small CSR-file stub answers reads on
//   the shared bus and flags unimplemented addresses; address 0x7C1 reads
//   fine but rejects writes. Each table entry holds one instruction, its
//   operands and the hand-computed observable result.
// ---------------------------------------------------------------------------
module tb_csr_sequencer;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [11:0] csr_addr;
    wire  [31:0] csr_bus;
    logic        csr_read;
    logic        csr_write;
    logic [1:0]  csr_write_type;
    logic        csr_invalid;
    logic        busy;
    logic        done;
    logic        illegal;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    always #5 clk = ~clk;

    csr_sequencer #(.XLEN(32), .CSR_AW(12)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .instr          (instr),
        .rs1_val        (rs1_val),
        .csr_addr       (csr_addr),
        .csr_bus        (csr_bus),
        .csr_read       (csr_read),
        .csr_write      (csr_write),
        .csr_write_type (csr_write_type),
        .csr_invalid    (csr_invalid),
        .busy           (busy),
        .done           (done),
        .illegal        (illegal),
        .rd_we          (rd_we),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data)
    );

    // ---------------- CSR file stub ----------------
    logic [31:0] csr_mem [0:4095];
    logic        probe;
    logic [31:0] probe_val;

    function automatic logic readable(input logic [11:0] a);
        case (a)
            CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
            CSR_MCAUSE, CSR_MHARTID, 12'h7C1: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic writable(input logic [11:0] a);
        return readable(a) && (a != 12'h7C1);
    endfunction

    // The bench drives the bus during reads, and when probing that the DUT
    // has released it (a still-driving DUT would corrupt probe_val).
    assign csr_bus = (csr_read || probe) ? (probe ? probe_val : csr_mem[csr_addr]) : 32'hzzzz_zzzz;
    assign csr_invalid = (csr_read && !readable(csr_addr)) || (csr_write && !writable(csr_addr));

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ci(input logic [11:0] csr, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
        return {csr, rs1, f3, rd, 7'h73};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] old;     // value the stub returns for this CSR
        int          lat;     // edges from the start edge to done
        int          reads;
        int          writes;
        logic [1:0]  wt;
        logic [31:0] wdata;
        logic        ill;
        logic        rwe;
        logic [4:0]  rd;
        logic [31:0] rdata;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] i, input logic [31:0] r, input logic [31:0] o,
                                input int l, input int nr, input int nw, input logic [1:0] wt,
                                input logic [31:0] wd, input logic il, input logic we,
                                input logic [4:0] rd, input logic [31:0] rdat);
        vec_t v;
        v.instr = i;  v.rs1 = r;   v.old = o;   v.lat = l;
        v.reads = nr; v.writes = nw; v.wt = wt; v.wdata = wd;
        v.ill = il;   v.rwe = we;  v.rd = rd;   v.rdata = rdat;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int          cyc;
        int          reads;
        int          writes;
        int          both;
        int          we_cnt;
        logic        got_done;
        logic        got_ill;
        logic [4:0]  got_rd;
        logic [31:0] got_rdata;
        logic [1:0]  last_wt;
        logic [31:0] last_wd;
        logic [11:0] strobe_addr;
        string       p;

        p = $sformatf("v%0d", idx);
        csr_mem[v.instr[31:20]] = v.old;
        instr   = v.instr;
        rs1_val = v.rs1;
        start   = 1'b1;
        cyc = 0; reads = 0; writes = 0; both = 0; we_cnt = 0;
        got_done = 1'b0; got_ill = 1'b0; got_rd = '0; got_rdata = '0;
        last_wt = '0; last_wd = '0; strobe_addr = '0;

        step();
        // Scramble the inputs so anything the DUT failed to latch shows up.
        start   = 1'b0;
        instr   = 32'hFFFF_FFFF;
        rs1_val = 32'h0;
        forever begin
            cyc++;
            if (csr_read || csr_write) strobe_addr = csr_addr;
            if (csr_read) reads++;
            if (csr_write) begin
                writes++;
                last_wt = csr_write_type;
                last_wd = csr_bus;
            end
            if (csr_read && csr_write) both++;
            if (rd_we) we_cnt++;
            if (done) begin
                got_done  = 1'b1;
                got_ill   = illegal;
                got_rd    = rd_addr;
                got_rdata = rd_data;
                break;
            end
            if (cyc >= 10) break;
            step();
        end

        check({p, " done seen"}, 32'(got_done), 32'd1);
        check({p, " latency"}, 32'(cyc), 32'(v.lat));
        check({p, " illegal"}, 32'(got_ill), 32'(v.ill));
        check({p, " rd_we pulses"}, 32'(we_cnt), 32'(v.rwe));
        check({p, " read strobes"}, 32'(reads), 32'(v.reads));
        check({p, " write strobes"}, 32'(writes), 32'(v.writes));
        check({p, " read+write overlap"}, 32'(both), 32'd0);
        if (v.rwe) begin
            check({p, " rd_addr"}, 32'(got_rd), 32'(v.rd));
            check({p, " rd_data"}, got_rdata, v.rdata);
        end
        if (v.reads + v.writes > 0) check({p, " csr_addr"}, 32'(strobe_addr), 32'(v.instr[31:20]));
        if (v.writes > 0) begin
            check({p, " write_type"}, 32'(last_wt), 32'(v.wt));
            check({p, " write data"}, last_wd, v.wdata);
        end
        step();
        check({p, " idle after done"}, 32'(busy), 32'd0);
    endtask

    vec_t vecs [12];

    initial begin
        int dones;
        int writes;

        for (int i = 0; i < 4096; i++) csr_mem[i] = 32'h0;
        rst = 1'b1; start = 1'b0; instr = '0; rs1_val = '0;
        probe = 1'b0; probe_val = '0;

        vecs[0]  = mk(ci(CSR_MSCRATCH, 5'd1, F3_CSRRW, 5'd5), 32'hDEADBEEF, 32'h12,
                      3, 1, 1, 2'b01, 32'hDEADBEEF, 1'b0, 1'b1, 5'd5, 32'h12);
        vecs[1]  = mk(ci(CSR_MCAUSE, 5'd0, F3_CSRRS, 5'd3), 32'h0000FFFF, 32'h7,
                      2, 1, 0, 2'b00, 32'h0, 1'b0, 1'b1, 5'd3, 32'h7);
        vecs[2]  = mk(ci(CSR_MEPC, 5'd3, F3_CSRRCI, 5'd0), 32'hAAAAAAAA, 32'h100,
                      3, 1, 1, 2'b11, 32'h3, 1'b0, 1'b0, 5'd0, 32'h0);
        vecs[3]  = mk(ci(12'h7C0, 5'd2, F3_CSRRW, 5'd4), 32'h1, 32'hBAD,
                      2, 1, 0, 2'b00, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        vecs[4]  = mk(ci(CSR_MHARTID, 5'd1, F3_CSRRW, 5'd6), 32'h5, 32'h0,
                      1, 0, 0, 2'b00, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        vecs[5]  = mk(ci(CSR_MHARTID, 5'd0, F3_CSRRS, 5'd2), 32'h9, 32'h0,
                      2, 1, 0, 2'b00, 32'h0, 1'b0, 1'b1, 5'd2, 32'h0);
        vecs[6]  = mk(ci(CSR_MTVEC, 5'd7, F3_CSRRW, 5'd0), 32'h80000100, 32'h44,
                      2, 0, 1, 2'b01, 32'h80000100, 1'b0, 1'b0, 5'd0, 32'h0);
        vecs[7]  = mk(ci(CSR_MSCRATCH, 5'd1, 3'b000, 5'd1), 32'h1, 32'h0,
                      1, 0, 0, 2'b00, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        vecs[8]  = mk(ci(CSR_MSCRATCH, 5'd1, 3'b100, 5'd1), 32'h1, 32'h0,
                      1, 0, 0, 2'b00, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        vecs[9]  = mk(ci(CSR_MSTATUS, 5'h1F, F3_CSRRSI, 5'd8), 32'h12345678, 32'h1800,
                      3, 1, 1, 2'b10, 32'h1F, 1'b0, 1'b1, 5'd8, 32'h1800);
        vecs[10] = mk(ci(CSR_MHARTID, 5'd0, F3_CSRRWI, 5'd9), 32'h0, 32'h0,
                      1, 0, 0, 2'b00, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        vecs[11] = mk(ci(12'h7C1, 5'd1, F3_CSRRW, 5'd10), 32'h600D, 32'h55,
                      3, 1, 1, 2'b01, 32'h600D, 1'b1, 1'b0, 5'd0, 32'h0);

        // ---------------- reset state ----------------
        step();
        step();
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst illegal", 32'(illegal), 32'd0);
        check("rst rd_we", 32'(rd_we), 32'd0);
        check("rst csr_read", 32'(csr_read), 32'd0);
        check("rst csr_write", 32'(csr_write), 32'd0);
        check("rst write_type", 32'(csr_write_type), 32'd0);
        check("rst rd_data", rd_data, 32'd0);
        check("rst rd_addr", 32'(rd_addr), 32'd0);
        check("rst csr_addr", 32'(csr_addr), 32'd0);
        probe_val = 32'hA5A5_0F0F; probe = 1'b1; #1;
        check("rst bus released", csr_bus, 32'hA5A5_0F0F);
        probe = 1'b0;
        rst = 1'b0;
        step();

        // ---------------- table ----------------
        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // ---------------- start while busy / in the done cycle ----------------
        csr_mem[CSR_MSCRATCH] = 32'h33;
        instr   = ci(CSR_MSCRATCH, 5'd4, F3_CSRRW, 5'd7);
        rs1_val = 32'h1111_2222;
        start   = 1'b1;
        dones = 0; writes = 0;
        for (int i = 0; i < 4; i++) begin    // start edge, two busy edges, done-cycle edge
            step();
            if (done) dones++;
            if (csr_write) writes++;
        end
        check("start in done cycle ignored", 32'(busy), 32'd0);
        step();                              // still requesting: accepted now
        check("start accepted after done", 32'(busy), 32'd1);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (csr_write) writes++;
            step();
            if (done) dones++;
        end
        check("busy-start done count", 32'(dones), 32'd2);
        check("busy-start write count", 32'(writes), 32'd2);
        check("busy-start rd_data", rd_data, 32'h33);

        // ---------------- reset during WRITE ----------------
        instr   = ci(CSR_MSCRATCH, 5'd2, F3_CSRRW, 5'd5);
        rs1_val = 32'hCAFE_F00D;
        start   = 1'b1;
        step();                              // T: enter READ
        start = 1'b0;
        step();                              // T+1: enter WRITE
        check("pre-rst csr_write", 32'(csr_write), 32'd1);
        check("pre-rst bus data", csr_bus, 32'hCAFE_F00D);
        rst = 1'b1;
        step();
        check("mid-rst busy", 32'(busy), 32'd0);
        check("mid-rst done", 32'(done), 32'd0);
        check("mid-rst csr_write", 32'(csr_write), 32'd0);
        check("mid-rst rd_we", 32'(rd_we), 32'd0);
        probe_val = 32'h5A5A_1234; probe = 1'b1; #1;
        check("mid-rst bus released", csr_bus, 32'h5A5A_1234);
        probe = 1'b0;
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done || rd_we) dones++;
        end
        check("post-rst no done/rd_we", 32'(dones), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
